// File: rtl/conv_task_sched_pkg.sv
// Shared types for the convolution task scheduler: descriptor layout and FSM states.
package conv_task_sched_pkg;

  localparam int unsigned TASK_DESC_W = 40;

  typedef struct packed {
    logic [1:0] mode;
    logic [7:0] idx_cnt;
    logic [7:0] trip_cnt;
    logic       is_new;
    logic       pad_u;
    logic       pad_l;
    logic [5:0] lim_r;
    logic [5:0] lim_d;
    logic [5:0] row_cnt;
    logic       last;
  } task_desc_t;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_BUF = 3'd1,
    START    = 3'd2,
    RUN      = 3'd3,
    DRAIN    = 3'd4,
    FLUSH    = 3'd5,
    DONE     = 3'd6
  } sched_state_e;

endpackage

// File: rtl/conv_task_sched_perf_cnt.sv
// Saturating busy/stall/task counters for the task scheduler (built only with CONV_SCHED_PERF_EN).
module sched_perf_cnt #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_busy,
  input  logic         i_stall,
  input  logic         i_done,
  output logic [W-1:0] o_busy_cyc,
  output logic [W-1:0] o_stall_cyc,
  output logic [W-1:0] o_task_cnt
);

  logic [W-1:0] r_busy_cyc;
  logic [W-1:0] r_stall_cyc;
  logic [W-1:0] r_task_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy_cyc  <= '0;
      r_stall_cyc <= '0;
      r_task_cnt  <= '0;
    end else begin
      if (i_busy && (r_busy_cyc != '1))
        r_busy_cyc <= r_busy_cyc + 1'b1;
      if (i_stall && (r_stall_cyc != '1))
        r_stall_cyc <= r_stall_cyc + 1'b1;
      if (i_done && (r_task_cnt != '1))
        r_task_cnt <= r_task_cnt + 1'b1;
    end
  end

  assign o_busy_cyc  = r_busy_cyc;
  assign o_stall_cyc = r_stall_cyc;
  assign o_task_cnt  = r_task_cnt;

endmodule

// File: rtl/conv_task_sched.sv
// Per-PE convolution task scheduler: descriptor accept, buffer wait, AGU start/run, drain, write-back.
// Performance counters are built only when CONV_SCHED_PERF_EN is defined; otherwise they read 0.
module conv_task_sched
  import conv_task_sched_pkg::*;
#(
  parameter int unsigned DRAIN_CYC = 9,
  parameter int unsigned PERF_W    = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [TASK_DESC_W-1:0] task_desc,
  input  logic                   task_valid,
  output logic                   task_ready,
  input  logic                   buf_ready,
  output logic                   buf_free,
  output logic                   agu_start,
  input  logic                   agu_done,
  output logic [1:0]             conf_mode,
  output logic [7:0]             conf_idx_cnt,
  output logic [7:0]             conf_trip_cnt,
  output logic                   conf_is_new,
  output logic                   conf_pad_u,
  output logic                   conf_pad_l,
  output logic [5:0]             conf_lim_r,
  output logic [5:0]             conf_lim_d,
  output logic [5:0]             conf_row_cnt,
  output logic                   wb_req,
  input  logic                   wb_ack,
  output logic                   task_done,
  output logic                   busy,
  output logic [PERF_W-1:0]      perf_busy_cyc,
  output logic [PERF_W-1:0]      perf_stall_cyc,
  output logic [PERF_W-1:0]      perf_task_cnt
);

  sched_state_e r_state;
  sched_state_e w_state_nxt;
  task_desc_t   r_desc;
  logic [7:0]   r_drain_cnt;
  logic [7:0]   w_drain_nxt;
  logic         r_run_first;
  logic         w_accept;

  logic r_task_ready;
  logic r_busy;
  logic r_agu_start;
  logic r_buf_free;
  logic r_wb_req;
  logic r_task_done;

  assign w_accept = task_valid && r_task_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_drain_nxt = r_drain_cnt;
    case (r_state)
      IDLE:     if (w_accept) w_state_nxt = WAIT_BUF;
      WAIT_BUF: if (buf_ready) w_state_nxt = START;
      START:    w_state_nxt = RUN;
      RUN: begin
        // agu_done is still high from the previous task on the first RUN cycle
        if (!r_run_first && agu_done) begin
          w_state_nxt = DRAIN;
          w_drain_nxt = 8'(DRAIN_CYC - 1);
        end
      end
      DRAIN: begin
        if (r_drain_cnt == '0)
          w_state_nxt = r_desc.last ? FLUSH : DONE;
        else
          w_drain_nxt = r_drain_cnt - 1'b1;
      end
      FLUSH:    if (wb_ack) w_state_nxt = DONE;
      DONE:     w_state_nxt = IDLE;
      default:  w_state_nxt = IDLE;
    endcase
  end

  // Outputs are registered decodes of the next state, so they stay aligned with r_state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_drain_cnt  <= '0;
      r_run_first  <= 1'b0;
      r_task_ready <= 1'b0;
      r_busy       <= 1'b0;
      r_agu_start  <= 1'b0;
      r_buf_free   <= 1'b0;
      r_wb_req     <= 1'b0;
      r_task_done  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_drain_cnt  <= w_drain_nxt;
      r_run_first  <= (w_state_nxt == RUN) && (r_state != RUN);
      r_task_ready <= (w_state_nxt == IDLE);
      r_busy       <= (w_state_nxt != IDLE);
      r_agu_start  <= (w_state_nxt == START);
      r_buf_free   <= (w_state_nxt == DRAIN) && (r_state == RUN);
      r_wb_req     <= (w_state_nxt == FLUSH);
      r_task_done  <= (w_state_nxt == DONE);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_desc <= '0;
    else if (w_accept)
      r_desc <= task_desc_t'(task_desc);
  end

  assign task_ready    = r_task_ready;
  assign busy          = r_busy;
  assign agu_start     = r_agu_start;
  assign buf_free      = r_buf_free;
  assign wb_req        = r_wb_req;
  assign task_done     = r_task_done;

  assign conf_mode     = r_desc.mode;
  assign conf_idx_cnt  = r_desc.idx_cnt;
  assign conf_trip_cnt = r_desc.trip_cnt;
  assign conf_is_new   = r_desc.is_new;
  assign conf_pad_u    = r_desc.pad_u;
  assign conf_pad_l    = r_desc.pad_l;
  assign conf_lim_r    = r_desc.lim_r;
  assign conf_lim_d    = r_desc.lim_d;
  assign conf_row_cnt  = r_desc.row_cnt;

`ifdef CONV_SCHED_PERF_EN
  logic w_stall;

  assign w_stall = ((r_state == WAIT_BUF) && !buf_ready) ||
                   ((r_state == FLUSH) && !wb_ack);

  sched_perf_cnt #(
    .W (PERF_W)
  ) u_perf (
    .clk         (clk),
    .rst_n       (rst),
    .i_busy      (r_busy),
    .i_stall     (w_stall),
    .i_done      (r_task_done),
    .o_busy_cyc  (perf_busy_cyc),
    .o_stall_cyc (perf_stall_cyc),
    .o_task_cnt  (perf_task_cnt)
  );
`else
  assign perf_busy_cyc  = '0;
  assign perf_stall_cyc = '0;
  assign perf_task_cnt  = '0;
`endif

endmodule

// File: tb/tb_conv_task_sched.sv
// Self-checking bench for conv_task_sched: directed and randomized tasks against an event-time model.
module tb_conv_task_sched;

  localparam int unsigned D  = 9;
  localparam int unsigned PW = 32;
`ifdef CONV_SCHED_PERF_EN
  localparam bit PERF_ON = 1'b1;
`else
  localparam bit PERF_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [39:0]   task_desc;
  logic          task_valid, task_ready, buf_ready, buf_free, agu_start, agu_done;
  logic [1:0]    conf_mode;
  logic [7:0]    conf_idx_cnt, conf_trip_cnt;
  logic          conf_is_new, conf_pad_u, conf_pad_l;
  logic [5:0]    conf_lim_r, conf_lim_d, conf_row_cnt;
  logic          wb_req, wb_ack, task_done, busy;
  logic [PW-1:0] perf_busy_cyc, perf_stall_cyc, perf_task_cnt;

  conv_task_sched #(
    .DRAIN_CYC (D),
    .PERF_W    (PW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .task_desc      (task_desc),
    .task_valid     (task_valid),
    .task_ready     (task_ready),
    .buf_ready      (buf_ready),
    .buf_free       (buf_free),
    .agu_start      (agu_start),
    .agu_done       (agu_done),
    .conf_mode      (conf_mode),
    .conf_idx_cnt   (conf_idx_cnt),
    .conf_trip_cnt  (conf_trip_cnt),
    .conf_is_new    (conf_is_new),
    .conf_pad_u     (conf_pad_u),
    .conf_pad_l     (conf_pad_l),
    .conf_lim_r     (conf_lim_r),
    .conf_lim_d     (conf_lim_d),
    .conf_row_cnt   (conf_row_cnt),
    .wb_req         (wb_req),
    .wb_ack         (wb_ack),
    .task_done      (task_done),
    .busy           (busy),
    .perf_busy_cyc  (perf_busy_cyc),
    .perf_stall_cyc (perf_stall_cyc),
    .perf_task_cnt  (perf_task_cnt)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [39:0] m_conf;
  logic [31:0] m_busy, m_stall, m_tasks;

  function automatic logic [5:0] ctrl_vec();
    return {task_ready, busy, agu_start, buf_free, wb_req, task_done};
  endfunction

  function automatic logic [38:0] conf_vec();
    return {conf_mode, conf_idx_cnt, conf_trip_cnt, conf_is_new, conf_pad_u,
            conf_pad_l, conf_lim_r, conf_lim_d, conf_row_cnt};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_perf(input string tag);
    chk({tag, "_busy"},  64'(perf_busy_cyc),  PERF_ON ? 64'(m_busy)  : 64'd0);
    chk({tag, "_stall"}, 64'(perf_stall_cyc), PERF_ON ? 64'(m_stall) : 64'd0);
    chk({tag, "_tasks"}, 64'(perf_task_cnt),  PERF_ON ? 64'(m_tasks) : 64'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctrl"}, 64'(ctrl_vec()), 64'd0);
    chk({tag, "_conf"}, 64'(conf_vec()), 64'd0);
    chk_perf(tag);
  endtask

  // Called at a negedge in IDLE; leaves the bench at the negedge of the IDLE cycle that follows.
  task automatic idle(input int unsigned n);
    task_valid = 1'b0;
    agu_done   = 1'b1;
    for (int unsigned i = 0; i < n; i++) begin
      buf_ready = 1'(($urandom % 2));
      wb_ack    = 1'(($urandom % 2));
      @(negedge clk);
      chk("idle_ctrl", 64'(ctrl_vec()), 64'b100000);
      chk("idle_conf", 64'(conf_vec()), 64'(m_conf[39:1]));
    end
  endtask

  // Event times are counted in negedges k after the accept edge (k=0 is the accept cycle).
  task automatic run_task(input logic [39:0] d, input int unsigned bdel, input int unsigned lo_len,
                          input int unsigned adel, input bit stale, input bit hold_valid,
                          input bit abort);
    int unsigned ks, lo_s, lo_e, kd, kf, kdone, kabort;
    bit          last;
    logic [5:0]  exp;
    last   = d[0];
    ks     = bdel + 2;
    lo_s   = ks + 1 + (stale ? 1 : 0);
    lo_e   = lo_s + lo_len - 1;
    kd     = lo_e + 1;
    kf     = kd + D + 1;
    kdone  = last ? kf + adel + 1 : kd + D + 1;
    kabort = abort ? kd + 3 : 0;

    chk("accept_ready", 64'(ctrl_vec()), 64'b100000);
    chk("conf_before_accept", 64'(conf_vec()), 64'(m_conf[39:1]));
    task_desc  = d;
    task_valid = 1'b1;
    buf_ready  = 1'b0;
    agu_done   = 1'b1;
    wb_ack     = 1'(($urandom % 2));

    for (int unsigned k = 1; k <= kdone + 1; k++) begin
      @(negedge clk);
      exp = {k == kdone + 1, k <= kdone, k == ks, k == kd + 1,
             last && (k >= kf) && (k <= kf + adel), k == kdone};
      chk($sformatf("ctrl_k%0d", k), 64'(ctrl_vec()), 64'(exp));
      chk("conf_latched", 64'(conf_vec()), 64'(d[39:1]));
      if (k == kabort) begin
        rst        = 1'b0;
        task_valid = 1'b0;
        buf_ready  = 1'b0;
        agu_done   = 1'b1;
        wb_ack     = 1'b0;
        m_conf  = '0;
        m_busy  = '0;
        m_stall = '0;
        m_tasks = '0;
        #1;
        chk_all_zero("async_rst");
        @(negedge clk);
        chk_all_zero("rst_held");
        rst = 1'b1;
        @(negedge clk);
        chk("rst_release_ctrl", 64'(ctrl_vec()), 64'b100000);
        chk("rst_release_conf", 64'(conf_vec()), 64'd0);
        idle(D + 4);
        chk_perf("after_abort");
        return;
      end
      if (k <= kdone) begin
        task_valid = hold_valid ? 1'b1 : 1'(($urandom % 2));
        task_desc  = {8'($urandom), 32'($urandom)};
        buf_ready  = (k > bdel) && (k <= kd);
        agu_done   = !((k >= lo_s) && (k <= lo_e));
        if (last && (k >= kf) && (k <= kf + adel))
          wb_ack = (k == kf + adel);
        else
          wb_ack = 1'(($urandom % 2));
      end
    end
    m_conf  = d;
    m_busy  = m_busy + kdone;
    m_stall = m_stall + bdel + (last ? adel : 0);
    m_tasks = m_tasks + 1;
    chk_perf("task_end");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [39:0] d;
    rst        = 1'b1;
    task_desc  = '0;
    task_valid = 1'b0;
    buf_ready  = 1'b0;
    agu_done   = 1'b1;
    wb_ack     = 1'b0;
    m_conf     = '0;
    m_busy     = '0;
    m_stall    = '0;
    m_tasks    = '0;
    #1 rst = 1'b0;
    #1;
    chk_all_zero("reset");
    task_valid = 1'b1;
    @(negedge clk);
    chk_all_zero("reset_held");
    rst = 1'b1;
    @(negedge clk);
    chk("first_ready", 64'(ctrl_vec()), 64'b100000);

    // Plain task, buffers ready, long AGU run.
    d = 40'hA5_3C_7E_5A_D2;
    d[0] = 1'b0;
    run_task(d, 0, 20, 0, 0, 0, 0);
    idle(2);
    // Buffers arrive 7 cycles late.
    d = 40'h5B_12_34_56_78;
    d[0] = 1'b0;
    run_task(d, 7, 3, 0, 0, 0, 0);
    idle(1);
    // Group-final task, ack arrives after 4 cycles.
    d = 40'hC3_FF_00_AA_55;
    d[0] = 1'b1;
    run_task(d, 1, 2, 4, 0, 0, 0);
    idle(1);
    // Back-to-back with valid held high.
    d = 40'h12_34_56_78_9A;
    run_task(d, 0, 1, 2, 0, 1, 0);
    d = 40'hFE_DC_BA_98_76;
    run_task(d, 0, 2, 0, 0, 1, 0);
    idle(1);
    // Stale agu_done high through the first RUN cycle.
    d = 40'h0F_F0_0F_F0_0E;
    run_task(d, 2, 4, 0, 1, 0, 0);
    idle(1);

    for (int i = 0; i < 20; i++) begin
      d = {8'($urandom), 32'($urandom)};
      run_task(d, $urandom_range(0, 6), $urandom_range(1, 8), $urandom_range(0, 5),
               1'(($urandom % 2)), 1'(($urandom % 2)), 0);
      idle($urandom_range(0, 2));
    end

    // Reset during DRAIN, then a clean task afterwards.
    d = 40'h77_66_55_44_33;
    run_task(d, 1, 3, 2, 0, 1, 1);
    d = 40'h3A_5A_7A_9A_BB;
    run_task(d, 0, 2, 1, 0, 0, 0);
    idle(1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
